// File: rtl/alu_wb_pkg.sv
// ALU writeback stage shared types and constants.
// Optional bypass outputs are enabled with ALU_WB_BYPASS_EN.
package alu_wb_pkg;

  localparam int GPR_IDX_W = 3;
  localparam int ALU_W     = 32;

  localparam logic [ALU_W-1:0] EFLAGS_RESET = 32'h0000_0002;

  localparam int CF_BIT   = 0;
  localparam int RSVD_BIT = 1;
  localparam int PF_BIT   = 2;
  localparam int AF_BIT   = 4;
  localparam int ZF_BIT   = 6;
  localparam int SF_BIT   = 7;
  localparam int OF_BIT   = 11;

  typedef struct packed {
    logic [ALU_W-1:0]     result;
    logic [ALU_W-1:0]     flags;
    logic [ALU_W-1:0]     mask;
    logic [GPR_IDX_W-1:0] dst;
    logic                 reg_we;
  } entry_t;

  function automatic logic [ALU_W-1:0] merge_flags(
    input logic [ALU_W-1:0] cur,
    input logic [ALU_W-1:0] flags,
    input logic [ALU_W-1:0] mask
  );
    logic [ALU_W-1:0] r;
    r = (cur & ~mask) | (flags & mask);
    r[RSVD_BIT] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/alu_wb_if.sv
// Producer/consumer bundle around the ALU writeback stage.
// master = environment side, slave = stage side.
interface alu_wb_if #(
  parameter int DATA_W = 32
);
  import alu_wb_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_W-1:0]    in_result;
  logic [DATA_W-1:0]    in_flags;
  logic [DATA_W-1:0]    in_flags_mask;
  logic [GPR_IDX_W-1:0] in_dst;
  logic                 in_reg_we;

  logic                 wb_valid;
  logic                 wb_ready;
  logic [DATA_W-1:0]    wb_result;
  logic [GPR_IDX_W-1:0] wb_dst;
  logic                 wb_reg_we;

  modport master (
    output in_valid, in_result, in_flags,
    output in_flags_mask, in_dst, in_reg_we,
    input  in_ready,
    input  wb_valid, wb_result, wb_dst, wb_reg_we,
    output wb_ready
  );

  modport slave (
    input  in_valid, in_result, in_flags,
    input  in_flags_mask, in_dst, in_reg_we,
    output in_ready,
    output wb_valid, wb_result, wb_dst, wb_reg_we,
    input  wb_ready
  );

endinterface

// File: rtl/alu_wb_fifo.sv
// Generic synchronous in-order FIFO with flush.
// Exposes its storage and read pointer for youngest-entry lookups.
module alu_wb_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            wdata,
  output logic [WIDTH-1:0]            rdata,
  output logic [CNT_W-1:0]            count,
  output logic                        full,
  output logic                        empty,
  output logic [DEPTH-1:0][WIDTH-1:0] mem_o,
  output logic [PTR_W-1:0]            rptr_o
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]            wptr_q, wptr_d;
  logic [PTR_W-1:0]            rptr_q, rptr_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic                        push_ok;
  logic                        pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem_q[rptr_q];
  assign count   = count_q;
  assign mem_o   = mem_q;
  assign rptr_o  = rptr_q;

  // Next pointers/count/storage; flush wins over push and pop.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) begin
        mem_d[wptr_q] = wdata;
        wptr_d        = wptr_q + 1'b1;
      end
      if (pop_ok) begin
        rptr_d = rptr_q + 1'b1;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/alu_wb_stage.sv
// ALU result buffer feeding GPR writeback, plus architectural EFLAGS.
// Define ALU_WB_BYPASS_EN to add the byp_* forwarding outputs.
module alu_wb_stage
  import alu_wb_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  alu_wb_if.slave              bus,
  output logic [DATA_W-1:0]    eflags
`ifdef ALU_WB_BYPASS_EN
  ,
  output logic                 byp_valid,
  output logic [GPR_IDX_W-1:0] byp_dst,
  output logic [DATA_W-1:0]    byp_result
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = $bits(entry_t);

  entry_t                      in_e;
  entry_t                      head_e;
  logic [CNT_W-1:0]            count;
  logic                        full;
  logic                        empty;
  logic                        wb_valid;
  logic                        retire;
  logic [DATA_W-1:0]           eflags_q, eflags_d;

  // Pack the incoming ALU result into a buffer entry.
  always_comb begin
    in_e        = '0;
    in_e.result = bus.in_result;
    in_e.flags  = bus.in_flags;
    in_e.mask   = bus.in_flags_mask;
    in_e.dst    = bus.in_dst;
    in_e.reg_we = bus.in_reg_we;
  end

`ifdef ALU_WB_BYPASS_EN
  logic [DEPTH-1:0][ENT_W-1:0] mem;
  logic [PTR_W-1:0]            rptr;
`endif

  alu_wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (bus.in_valid),
    .pop   (bus.wb_ready),
    .wdata (in_e),
    .rdata (head_e),
    .count (count),
    .full  (full),
    .empty (empty),
`ifdef ALU_WB_BYPASS_EN
    .mem_o (mem),
    .rptr_o(rptr)
`else
    .mem_o (),
    .rptr_o()
`endif
  );

  assign bus.in_ready = ~full;
  assign wb_valid     = ~empty;
  assign retire       = wb_valid & bus.wb_ready & ~flush;

  // Head presentation; payload forced to zero when nothing is valid.
  always_comb begin
    bus.wb_valid  = wb_valid;
    bus.wb_result = '0;
    bus.wb_dst    = '0;
    bus.wb_reg_we = 1'b0;
    if (wb_valid) begin
      bus.wb_result = head_e.result;
      bus.wb_dst    = head_e.dst;
      bus.wb_reg_we = head_e.reg_we;
    end
  end

  // Merge retiring flags under the entry mask; bit 1 always reads 1.
  always_comb begin
    eflags_d = eflags_q;
    if (retire) begin
      eflags_d = merge_flags(eflags_q, head_e.flags, head_e.mask);
    end
  end

  // Architectural EFLAGS register.
  always_ff @(posedge clk) begin
    if (reset) begin
      eflags_q <= EFLAGS_RESET;
    end else begin
      eflags_q <= eflags_d;
    end
  end

  assign eflags = eflags_q;

`ifdef ALU_WB_BYPASS_EN
  logic [PTR_W-1:0] byp_idx;
  entry_t           byp_e;

  // Scan oldest to youngest so the last GPR writer found wins.
  always_comb begin
    byp_valid  = 1'b0;
    byp_dst    = '0;
    byp_result = '0;
    byp_idx    = '0;
    byp_e      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      byp_idx = rptr + PTR_W'(k);
      byp_e   = mem[byp_idx];
      if ((CNT_W'(k) < count) && byp_e.reg_we) begin
        byp_valid  = 1'b1;
        byp_dst    = byp_e.dst;
        byp_result = byp_e.result;
      end
    end
    if (flush) begin
      byp_valid  = 1'b0;
      byp_dst    = '0;
      byp_result = '0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed self-checking bench for alu_wb_stage.
// Bypass checks are compiled in when ALU_WB_BYPASS_EN is defined.
module tb_alu_wb_stage;
  import alu_wb_pkg::*;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [31:0] eflags;
  int          checks;
  int          failures;

`ifdef ALU_WB_BYPASS_EN
  logic        byp_valid;
  logic [2:0]  byp_dst;
  logic [31:0] byp_result;
`endif

  alu_wb_if #(.DATA_W(32)) bus ();

  alu_wb_stage #(
    .DEPTH (2),
    .DATA_W(32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .bus       (bus),
    .eflags    (eflags)
`ifdef ALU_WB_BYPASS_EN
    ,
    .byp_valid (byp_valid),
    .byp_dst   (byp_dst),
    .byp_result(byp_result)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r,
                       input logic [31:0] f, input logic [31:0] m,
                       input logic [2:0] d, input logic we);
    bus.in_valid      = v;
    bus.in_result     = r;
    bus.in_flags      = f;
    bus.in_flags_mask = m;
    bus.in_dst        = d;
    bus.in_reg_we     = we;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    flush = 1'b0;
    bus.wb_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0);
    step();
    step();
    checks++;
    if (bus.wb_valid !== 1'b0 || bus.wb_reg_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got v=%b we=%b want 0 0",
               bus.wb_valid, bus.wb_reg_we);
    end
    checks++;
    if (bus.wb_result !== 32'h0 || bus.wb_dst !== 3'd0) begin
      failures++;
      $display("FAIL reset_payload got %h/%0d want 0/0",
               bus.wb_result, bus.wb_dst);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
    checks++;
    if (eflags !== 32'h0000_0002) begin
      failures++;
      $display("FAIL reset_eflags got %h want 00000002", eflags);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    bus.wb_ready = 1'b1;
    drive(1'b1, 32'hFFFF_FFFF, 32'h80, 32'h8D5, 3'd0, 1'b1);
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0);
    checks++;
    if (bus.wb_valid !== 1'b1 || bus.wb_result !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL single_head got v=%b r=%h want 1 ffffffff",
               bus.wb_valid, bus.wb_result);
    end
    checks++;
    if (bus.wb_reg_we !== 1'b1 || bus.wb_dst !== 3'd0) begin
      failures++;
      $display("FAIL single_we got we=%b d=%0d want 1 0",
               bus.wb_reg_we, bus.wb_dst);
    end
    step();
    checks++;
    if (eflags !== 32'h0000_0082 || bus.wb_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_retire got ef=%h v=%b want 00000082 0",
               eflags, bus.wb_valid);
    end
  endtask

  task automatic test_backpressure();
    bus.wb_ready = 1'b0;
    drive(1'b1, 32'h0100_0100, 32'h0, 32'h0, 3'd1, 1'b1);
    step();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.wb_result !== 32'h0100_0100) begin
      failures++;
      $display("FAIL bp_first got rdy=%b r=%h want 1 01000100",
               bus.in_ready, bus.wb_result);
    end
    drive(1'b1, 32'h3661_3660, 32'h0, 32'h0, 3'd2, 1'b1);
    step();
    checks++;
    if (bus.in_ready !== 1'b0 || bus.wb_result !== 32'h0100_0100) begin
      failures++;
      $display("FAIL bp_full got rdy=%b r=%h want 0 01000100",
               bus.in_ready, bus.wb_result);
    end
    drive(1'b1, 32'hCAAD_CAAD, 32'h0, 32'h0, 3'd3, 1'b1);
    step();
    checks++;
    if (bus.in_ready !== 1'b0 || bus.wb_result !== 32'h0100_0100) begin
      failures++;
      $display("FAIL bp_held got rdy=%b r=%h want 0 01000100",
               bus.in_ready, bus.wb_result);
    end
    bus.wb_ready = 1'b1;
    step();
    checks++;
    if (bus.wb_result !== 32'h3661_3660 || bus.wb_dst !== 3'd2 ||
        bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_pop1 got r=%h d=%0d rdy=%b want 36613660 2 1",
               bus.wb_result, bus.wb_dst, bus.in_ready);
    end
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0);
    checks++;
    if (bus.wb_result !== 32'hCAAD_CAAD || bus.wb_dst !== 3'd3 ||
        bus.wb_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_pop2 got r=%h d=%0d v=%b want caadcaad 3 1",
               bus.wb_result, bus.wb_dst, bus.wb_valid);
    end
    step();
    checks++;
    if (bus.wb_valid !== 1'b0 || eflags !== 32'h0000_0082) begin
      failures++;
      $display("FAIL bp_drain got v=%b ef=%h want 0 00000082",
               bus.wb_valid, eflags);
    end
  endtask

  task automatic test_full_pop_push();
    bus.wb_ready = 1'b0;
    drive(1'b1, 32'h1111_0001, 32'h0, 32'h0, 3'd1, 1'b1);
    step();
    drive(1'b1, 32'h1111_0002, 32'h0, 32'h0, 3'd2, 1'b1);
    step();
    drive(1'b1, 32'h1111_0003, 32'h0, 32'h0, 3'd3, 1'b1);
    bus.wb_ready = 1'b1;
    step();
    checks++;
    if (bus.wb_result !== 32'h1111_0002 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_pop got r=%h rdy=%b want 11110002 1",
               bus.wb_result, bus.in_ready);
    end
    bus.wb_ready = 1'b0;
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0);
    checks++;
    if (bus.wb_result !== 32'h1111_0002 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_push_late got r=%h rdy=%b want 11110002 0",
               bus.wb_result, bus.in_ready);
    end
    bus.wb_ready = 1'b1;
    step();
    checks++;
    if (bus.wb_result !== 32'h1111_0003 || bus.wb_valid !== 1'b1) begin
      failures++;
      $display("FAIL full_third got r=%h v=%b want 11110003 1",
               bus.wb_result, bus.wb_valid);
    end
    step();
    checks++;
    if (bus.wb_valid !== 1'b0) begin
      failures++;
      $display("FAIL full_empty got v=%b want 0", bus.wb_valid);
    end
  endtask

  task automatic test_mask_merge();
    bus.wb_ready = 1'b1;
    drive(1'b1, 32'h0, 32'h0000_0803, 32'hFFFF_FFFF, 3'd0, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0);
    checks++;
    if (bus.wb_reg_we !== 1'b0) begin
      failures++;
      $display("FAIL merge_we got %b want 0", bus.wb_reg_we);
    end
    step();
    checks++;
    if (eflags !== 32'h0000_0803) begin
      failures++;
      $display("FAIL merge_setup got %h want 00000803", eflags);
    end
    drive(1'b1, 32'h0, 32'h0000_0040, 32'h0000_0041, 3'd0, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0);
    step();
    checks++;
    if (eflags !== 32'h0000_0842) begin
      failures++;
      $display("FAIL merge_cf_zf got %h want 00000842", eflags);
    end
    drive(1'b1, 32'h0, 32'hFFFF_FFFF, 32'h0, 3'd0, 1'b0);
    step();
    drive(1'b1, 32'h0, 32'h0, 32'h0000_0002, 3'd0, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0);
    step();
    checks++;
    if (eflags !== 32'h0000_0842) begin
      failures++;
      $display("FAIL merge_zero_rsvd got %h want 00000842", eflags);
    end
  endtask

  task automatic test_flush();
    bus.wb_ready = 1'b0;
    drive(1'b1, 32'hAAAA_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd4, 1'b1);
    step();
    drive(1'b1, 32'hAAAA_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd5, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0);
`ifdef ALU_WB_BYPASS_EN
    checks++;
    if (byp_valid !== 1'b1 || byp_dst !== 3'd4 ||
        byp_result !== 32'hAAAA_0001) begin
      failures++;
      $display("FAIL byp_youngest got v=%b d=%0d r=%h want 1 4 aaaa0001",
               byp_valid, byp_dst, byp_result);
    end
`endif
    bus.wb_ready = 1'b1;
    flush = 1'b1;
    #1;
`ifdef ALU_WB_BYPASS_EN
    checks++;
    if (byp_valid !== 1'b0) begin
      failures++;
      $display("FAIL byp_flush got %b want 0", byp_valid);
    end
`endif
    step();
    flush = 1'b0;
    checks++;
    if (bus.wb_valid !== 1'b0 || bus.wb_result !== 32'h0) begin
      failures++;
      $display("FAIL flush_valid got v=%b r=%h want 0 0",
               bus.wb_valid, bus.wb_result);
    end
    checks++;
    if (eflags !== 32'h0000_0842 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_eflags got ef=%h rdy=%b want 00000842 1",
               eflags, bus.in_ready);
    end
    drive(1'b1, 32'h1234_5678, 32'h0, 32'h0, 3'd6, 1'b1);
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0);
    checks++;
    if (bus.wb_result !== 32'h1234_5678 || bus.wb_dst !== 3'd6) begin
      failures++;
      $display("FAIL flush_refill got r=%h d=%0d want 12345678 6",
               bus.wb_result, bus.wb_dst);
    end
    step();
  endtask

  task automatic test_reset_mid();
    bus.wb_ready = 1'b1;
    drive(1'b1, 32'h0, 32'h0000_08C3, 32'hFFFF_FFFF, 3'd0, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0);
    step();
    checks++;
    if (eflags !== 32'h0000_08C3) begin
      failures++;
      $display("FAIL rst_setup got %h want 000008c3", eflags);
    end
    bus.wb_ready = 1'b0;
    drive(1'b1, 32'hBBBB_0001, 32'h0, 32'h0, 3'd1, 1'b1);
    step();
    drive(1'b1, 32'hBBBB_0002, 32'h0, 32'h0, 3'd2, 1'b1);
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_full got rdy=%b want 0", bus.in_ready);
    end
    reset = 1'b1;
    flush = 1'b1;
    step();
    reset = 1'b0;
    flush = 1'b0;
    checks++;
    if (bus.wb_valid !== 1'b0 || eflags !== 32'h0000_0002 ||
        bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid got v=%b ef=%h rdy=%b want 0 00000002 1",
               bus.wb_valid, eflags, bus.in_ready);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single();
    test_backpressure();
    test_full_pop_push();
    test_mask_merge();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
